// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit driving a single-port, word-addressed
// data memory. Loads extract and extend a byte, half or word. Sub-word stores
// go through a read-modify-write cycle.
// Optional feature macro: LSU_ALIGN_CHECK_EN. When it is defined, misaligned,
// out-of-range and illegal-funct3 requests complete with resp_err=1 and never
// touch memory. When it is undefined, low address bits are masked to the
// access size, the address wraps modulo the memory size, and an illegal funct3
// is treated as a word access.
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, uns_q, err_q;
    logic [1:0]  sz_q, off_q;
    logic [31:0] wdata_q, rdata_q, mem_addr_q;

    logic        acc;
    logic [1:0]  acc_sz, acc_off;
    logic        acc_err;
    logic [31:0] acc_idx;

    assign acc     = req_valid && req_ready;
    assign acc_idx = {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};

    // Access size from funct3: 0=byte, 1=half, 2=word (also the fallback for illegal codes)
    always_comb begin
        acc_sz = 2'd2;
        if (req_we) begin
            case (req_funct3)
                3'd0:    acc_sz = 2'd0;
                3'd1:    acc_sz = 2'd1;
                default: acc_sz = 2'd2;
            endcase
        end else begin
            case (req_funct3)
                3'd0, 3'd4: acc_sz = 2'd0;
                3'd1, 3'd5: acc_sz = 2'd1;
                default:    acc_sz = 2'd2;
            endcase
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    logic illegal, misal, oor;
    // Checked build: flag the error at accept and keep the raw byte offset
    always_comb begin
        illegal = req_we ? (req_funct3 > 3'd2)
                         : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
        misal   = (acc_sz == 2'd1 && req_addr[0]) || (acc_sz == 2'd2 && |req_addr[1:0]);
        oor     = |req_addr[31:ADDR_W+2];
        acc_err = illegal | misal | oor;
        acc_off = req_addr[1:0];
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    // Unchecked build: force the offset to the access alignment, never error
    always_comb begin
        acc_err = 1'b0;
        case (acc_sz)
            2'd0:    acc_off = req_addr[1:0];
            2'd1:    acc_off = {req_addr[1], 1'b0};
            default: acc_off = 2'd0;
        endcase
    end
`endif

    // State register; reset aborts any in-flight access
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (acc) begin
                if (acc_err)           state_d = RESP;
                else if (!req_we)      state_d = LOAD;
                else if (acc_sz == 2'd2) state_d = WRITE;
                else                   state_d = RMW_RD;
            end
            LOAD:    state_d = RESP;
            RMW_RD:  state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [4:0]  sh;
    logic [31:0] shifted, load_ext, lane_mask, merged;
    assign sh      = {off_q, 3'b000};
    assign shifted = mem_rdata >> sh;

    // Lane extraction/extension for loads and lane merge for sub-word stores
    always_comb begin
        case (sz_q)
            2'd0:    load_ext = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_ext = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
        lane_mask = ((sz_q == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        merged    = (mem_rdata & ~lane_mask) | ((wdata_q << sh) & lane_mask);
    end

    // Request latch, load capture and RMW merge capture
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
            sz_q       <= 2'd0;
            off_q      <= 2'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            mem_addr_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: if (acc) begin
                    we_q    <= req_we;
                    uns_q   <= !req_we && req_funct3[2];
                    err_q   <= acc_err;
                    sz_q    <= acc_sz;
                    off_q   <= acc_off;
                    wdata_q <= req_wdata;
                    rdata_q <= 32'd0;
                    // An erroring request never reaches memory, so the address holds
                    if (!acc_err) mem_addr_q <= acc_idx;
                end
                LOAD:    rdata_q <= load_ext;
                RMW_RD:  wdata_q <= merged;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; memory and response strobes are 0 elsewhere
    always_comb begin
        req_ready  = (state_q == IDLE) && !rst;
        mem_addr   = mem_addr_q;
        mem_rw     = (state_q == WRITE);
        mem_wdata  = (state_q == WRITE) ? wdata_q : 32'd0;
        resp_valid = (state_q == RESP);
        resp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
        resp_err   = (state_q == RESP) && err_q;
    end

    logic unused_we;
    assign unused_we = we_q;

endmodule
